latency_monitor: RTL
====================

LATENCY_MONITOR -- requirements
Module: latency_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, 4: number of independent monitor channels, 1..16.
REQ-002 SHALL have parameter XLEN, 32: PC and data width.
REQ-003 SHALL have parameter CNT_W, 16: latency counter width.
REQ-004 SHALL have parameter TIMEOUT, 1000: timeout in cycles, 1..2^CNT_W-1; elaboration error otherwise.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port arm  input  NUM_CH  per-channel single-cycle arm strobe.
REQ-008 SHALL have port arm_pc  input  NUM_CH*XLEN  per-channel start PC.
REQ-009 SHALL have port arm_rd  input  NUM_CH*5  per-channel destination register index.
REQ-010 SHALL have port arm_exp  input  NUM_CH*XLEN  per-channel expected writeback value.
REQ-011 SHALL have port pc_current  input  XLEN  fetch-stage PC from the CPU pipeline.
REQ-012 SHALL have port wb_en, wb_rd, wb_data  input  1/5/XLEN  register-file write port.
REQ-013 SHALL have port ch_state  output  NUM_CH*2  per-channel state encoding.
REQ-014 SHALL have port latency, done, pass, timeout  output  NUM_CH*CNT_W/NUM_CH/NUM_CH/NUM_CH  per-channel results.
REQ-015 SHALL have port any_fail  output  1  OR over channels of done & ~pass.

Function
REQ-016 Each channel SHALL run FSM IDLE=0, ARMED=1, TIMING=2, DONE=3.
REQ-017 arm[i] in any state SHALL latch arm_pc/rd/exp, clear latency/done/pass/timeout, enter ARMED next cycle; arm has priority over every other event that cycle.
REQ-018 ARMED: pc_current == latched PC at cycle N SHALL enter TIMING with counter=1 visible at N+1; wb in cycle N ignored.
REQ-019 TIMING: counter SHALL increment each cycle, so counter at cycle M equals M-N; further PC matches ignored.
REQ-020 TIMING: wb_en && wb_rd == latched rd at cycle M SHALL set latency=M-N, done=1, pass=(wb_data==exp), state DONE at M+1.
REQ-021 Latched rd==0 SHALL complete on PC match: latency=0, done=1, pass=1, skip TIMING.
REQ-022 TIMING with counter == TIMEOUT and no matching wb SHALL enter DONE with latency=TIMEOUT, timeout=1, pass=0; matching wb in that same cycle wins.
REQ-023 DONE SHALL hold all results until next arm or reset.
REQ-024 Channels SHALL be independent; one wb may complete several channels in the same cycle.
REQ-025 any_fail SHALL be combinational from registered done/pass.

Reset
REQ-026 reset SHALL immediately, without a clock edge, force all channels IDLE and latency, done, pass, timeout, any_fail, counters and latched arm fields to 0.
REQ-027 reset asserted mid-TIMING SHALL discard the measurement; no done pulse after release.

Configuration
REQ-028 With LATENCY_MONITOR_MINMAX_EN defined, SHALL add outputs lat_min, lat_max (CNT_W each) tracking min/max latency over all pass=1 completions since reset, all simultaneous completions compared in one cycle; reset values all-ones and 0.
REQ-029 Without LATENCY_MONITOR_MINMAX_EN, those ports and their logic SHALL be absent.

Structure
REQ-030 Package latmon_pkg SHALL hold state enum, REG_IDX_W=5 and state-encoding constants.
REQ-031 Sub-module latmon_channel SHALL implement one channel FSM, instantiated NUM_CH times by generate; min/max and any_fail in top.

Verification
REQ-032 Arm ch0 pc=0x8 rd=3 exp=0xF; pc_current=0x8 at cycle 10, wb rd=3 data=0xF at cycle 14 -> done=1, pass=1, latency=4, state DONE.
REQ-033 Same, wb_data=0xE -> done=1, pass=0, any_fail=1.
REQ-034 TIMEOUT=20, PC match at cycle 10, no wb -> cycle 30 done=1, timeout=1, latency=20.
REQ-035 Re-arm ch1 mid-TIMING at counter=5 -> next cycle ARMED, latency=0, done=0.
REQ-036 Assert reset between clock edges mid-TIMING -> all outputs 0 before next edge; no completion after release.
REQ-037 MINMAX_EN: ch0 latency 3, ch2 latency 7 completing same cycle -> lat_min=3, lat_max=7.

Source files
------------

// File: rtl/latmon_pkg.sv
// Shared definitions for the latency monitor: per-channel state encoding and
// register-index width.
package latmon_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_TIMING = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ARMED  = ST_ARMED,
    S_TIMING = ST_TIMING,
    S_DONE   = ST_DONE
  } latmon_state_e;

endpackage

// File: rtl/latmon_channel.sv
// One latency-monitor channel: waits for its start PC, then counts cycles until
// the matching register writeback or timeout. Extra ports under LATENCY_MONITOR_MINMAX_EN.
module latmon_channel
  import latmon_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm_i,
  input  logic [XLEN-1:0]      arm_pc_i,
  input  logic [REG_IDX_W-1:0] arm_rd_i,
  input  logic [XLEN-1:0]      arm_exp_i,
  input  logic [XLEN-1:0]      pc_cur_i,
  input  logic                 wb_en_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  output logic [1:0]           state_o,
  output logic [CNT_W-1:0]     lat_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o
`ifdef LATENCY_MONITOR_MINMAX_EN
  ,
  output logic                 fin_ok_o,
  output logic [CNT_W-1:0]     fin_lat_o
`endif
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  latmon_state_e          state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [REG_IDX_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]        exp_q, exp_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   to_q, to_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_d    = rd_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    done_d  = done_q;
    pass_d  = pass_q;
    to_d    = to_q;
    // A new arm overrides whatever the channel was doing this cycle.
    if (arm_i) begin
      state_d = S_ARMED;
      pc_d    = arm_pc_i;
      rd_d    = arm_rd_i;
      exp_d   = arm_exp_i;
      cnt_d   = '0;
      lat_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (pc_cur_i == pc_q) begin
            if (rd_q == '0) begin
              state_d = S_DONE;
              lat_d   = '0;
              done_d  = 1'b1;
              pass_d  = 1'b1;
            end else begin
              state_d = S_TIMING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        S_TIMING: begin
          // A matching writeback beats the timeout when both land on the same cycle.
          if (wb_en_i && (wb_rd_i == rd_q)) begin
            state_d = S_DONE;
            lat_d   = cnt_q;
            done_d  = 1'b1;
            pass_d  = (wb_data_i == exp_q);
          end else if (cnt_q == TO_VAL) begin
            state_d = S_DONE;
            lat_d   = TO_VAL;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      rd_q    <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

  assign state_o   = state_q;
  assign lat_o     = lat_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = to_q;

`ifdef LATENCY_MONITOR_MINMAX_EN
  // Completion strobe for the cycle that moves the channel into DONE with a pass.
  assign fin_ok_o  = (state_d == S_DONE) && (state_q != S_DONE) && pass_d;
  assign fin_lat_o = lat_d;
`endif

endmodule

// File: rtl/latency_monitor.sv
// Multi-channel instruction latency monitor. Define LATENCY_MONITOR_MINMAX_EN to
// add lat_min/lat_max tracking over all passing completions.
module latency_monitor
  import latmon_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH-1:0]           arm,
  input  logic [NUM_CH*XLEN-1:0]      arm_pc,
  input  logic [NUM_CH*REG_IDX_W-1:0] arm_rd,
  input  logic [NUM_CH*XLEN-1:0]      arm_exp,
  input  logic [XLEN-1:0]             pc_current,
  input  logic                        wb_en,
  input  logic [REG_IDX_W-1:0]        wb_rd,
  input  logic [XLEN-1:0]             wb_data,
  output logic [NUM_CH*2-1:0]         ch_state,
  output logic [NUM_CH*CNT_W-1:0]     latency,
  output logic [NUM_CH-1:0]           done,
  output logic [NUM_CH-1:0]           pass,
  output logic [NUM_CH-1:0]           timeout,
  output logic                        any_fail
`ifdef LATENCY_MONITOR_MINMAX_EN
  ,
  output logic [CNT_W-1:0]            lat_min,
  output logic [CNT_W-1:0]            lat_max
`endif
);

  if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
    $error("latency_monitor: NUM_CH must be in 1..16");
  end
  if ((TIMEOUT < 1) || (longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1))) begin : g_bad_timeout
    $error("latency_monitor: TIMEOUT must be in 1..2**CNT_W-1");
  end

`ifdef LATENCY_MONITOR_MINMAX_EN
  logic [NUM_CH-1:0]       fin_ok;
  logic [NUM_CH*CNT_W-1:0] fin_lat;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    latmon_channel #(
      .XLEN    (XLEN),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .arm_i     (arm[i]),
      .arm_pc_i  (arm_pc[i*XLEN +: XLEN]),
      .arm_rd_i  (arm_rd[i*REG_IDX_W +: REG_IDX_W]),
      .arm_exp_i (arm_exp[i*XLEN +: XLEN]),
      .pc_cur_i  (pc_current),
      .wb_en_i   (wb_en),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .state_o   (ch_state[i*2 +: 2]),
      .lat_o     (latency[i*CNT_W +: CNT_W]),
      .done_o    (done[i]),
      .pass_o    (pass[i]),
      .timeout_o (timeout[i])
`ifdef LATENCY_MONITOR_MINMAX_EN
      ,
      .fin_ok_o  (fin_ok[i]),
      .fin_lat_o (fin_lat[i*CNT_W +: CNT_W])
`endif
    );
  end

  assign any_fail = |(done & ~pass);

`ifdef LATENCY_MONITOR_MINMAX_EN
  logic [CNT_W-1:0] lat_min_q, lat_min_d;
  logic [CNT_W-1:0] lat_max_q, lat_max_d;

  // Fold every passing completion of this cycle into the running extremes.
  always_comb begin
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (fin_ok[i]) begin
        if (fin_lat[i*CNT_W +: CNT_W] < lat_min_d) lat_min_d = fin_lat[i*CNT_W +: CNT_W];
        if (fin_lat[i*CNT_W +: CNT_W] > lat_max_d) lat_max_d = fin_lat[i*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else begin
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  assign lat_min = lat_min_q;
  assign lat_max = lat_max_q;
`endif

endmodule
